// File: rtl/memory_fifo_tester_if.sv
// rtl/memory_fifo_tester_if.sv - host-side load/transfer/drain signals of memory_fifo_tester
interface memory_fifo_tester_if #(
    parameter int DATA_W = 8
);
    logic              W_en;
    logic [DATA_W-1:0] port_A;
    logic              s_sig;
    logic              R_en;
    logic [DATA_W-1:0] port_D;
    logic              fifo_empty;
    logic              fifo_full;
    logic              xfer_done;

    modport master (
        output W_en, port_A, s_sig, R_en,
        input  port_D, fifo_empty, fifo_full, xfer_done
    );

    modport slave (
        input  W_en, port_A, s_sig, R_en,
        output port_D, fifo_empty, fifo_full, xfer_done
    );
endinterface

// File: rtl/memory_fifo_tester.sv
// rtl/memory_fifo_tester.sv - feature memory -> FIFO -> weight memory transfer block
module memory_fifo_tester #(
    parameter int DATA_W     = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input logic                   clk,
    input logic                   rst1,
    memory_fifo_tester_if.slave   bus
);
    localparam int MAW = $clog2(MEM_DEPTH);
    localparam int CW  = MAW + 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int PW  = FAW + 1;
    localparam logic [CW-1:0] MEM_DEPTH_C = CW'(MEM_DEPTH);
    localparam logic [4:0]    RD_CNT_MAX  = 5'd31;

    logic [DATA_W-1:0] feature_mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] feature_mem_d [MEM_DEPTH];
    logic [DATA_W-1:0] weight_mem_q  [MEM_DEPTH];
    logic [DATA_W-1:0] weight_mem_d  [MEM_DEPTH];
    logic [DATA_W-1:0] fifo_mem_q    [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d    [FIFO_DEPTH];

    logic [MAW-1:0]    wr_addr_q, wr_addr_d;
    logic [CW-1:0]     src_cnt_q, src_cnt_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [MAW-1:0]    j_q, j_d;
    logic [4:0]        read_sync_cntr_q, read_sync_cntr_d;
    logic [DATA_W-1:0] port_d_q, port_d_d;

    logic fifo_empty;
    logic fifo_full;
    logic push_en;
    logic pop_en;

    always_comb begin
        feature_mem_d    = feature_mem_q;
        weight_mem_d     = weight_mem_q;
        fifo_mem_d       = fifo_mem_q;
        wr_addr_d        = wr_addr_q;
        src_cnt_d        = src_cnt_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        j_d              = j_q;
        read_sync_cntr_d = read_sync_cntr_q;
        port_d_d         = port_d_q;

        // Extra wrap bit on each pointer separates full from empty when low bits match.
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[FAW-1:0] == rptr_q[FAW-1:0]) && (wptr_q[FAW] != rptr_q[FAW]);
        push_en    = bus.s_sig && !fifo_full && (src_cnt_q < MEM_DEPTH_C);
        pop_en     = bus.R_en && !fifo_empty;

        if (bus.W_en) begin
            feature_mem_d[wr_addr_q] = bus.port_A;
            wr_addr_d                = wr_addr_q + MAW'(1);
        end

        // Push reads feature_mem_q, so a same-cycle load to that entry is not seen.
        if (push_en) begin
            fifo_mem_d[wptr_q[FAW-1:0]] = feature_mem_q[src_cnt_q[MAW-1:0]];
            wptr_d                      = wptr_q + PW'(1);
            src_cnt_d                   = src_cnt_q + CW'(1);
        end

        if (pop_en) begin
            port_d_d        = fifo_mem_q[rptr_q[FAW-1:0]];
            weight_mem_d[j_q] = fifo_mem_q[rptr_q[FAW-1:0]];
            rptr_d          = rptr_q + PW'(1);
            j_d             = j_q + MAW'(1);
            if (read_sync_cntr_q != RD_CNT_MAX) begin
                read_sync_cntr_d = read_sync_cntr_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                feature_mem_q[i] <= '0;
                weight_mem_q[i]  <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_addr_q        <= '0;
            src_cnt_q        <= '0;
            wptr_q           <= '0;
            rptr_q           <= '0;
            j_q              <= '0;
            read_sync_cntr_q <= '0;
            port_d_q         <= '0;
        end else begin
            feature_mem_q    <= feature_mem_d;
            weight_mem_q     <= weight_mem_d;
            fifo_mem_q       <= fifo_mem_d;
            wr_addr_q        <= wr_addr_d;
            src_cnt_q        <= src_cnt_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            j_q              <= j_d;
            read_sync_cntr_q <= read_sync_cntr_d;
            port_d_q         <= port_d_d;
        end
    end

    assign bus.port_D     = port_d_q;
    assign bus.fifo_empty = fifo_empty;
    assign bus.fifo_full  = fifo_full;
    assign bus.xfer_done  = (src_cnt_q == MEM_DEPTH_C);
endmodule

// File: tb/tb_memory_fifo_tester.sv
// tb/tb_memory_fifo_tester.sv - directed, table-driven bench for memory_fifo_tester
module tb_memory_fifo_tester;
    typedef struct {
        logic       w_en;
        logic [7:0] a;
        logic       s;
        logic       r;
        logic [7:0] exp_d;
        logic       exp_e;
        logic       exp_f;
        logic       exp_x;
    } vec_t;

    logic clk;
    logic rst1;
    int   n_tests;
    int   n_fail;
    logic [7:0] feat [16] = '{8'd4, 8'd14, 8'd24, 8'd42, 8'd141, 8'd243, 8'd41, 8'd134,
                              8'd204, 8'd124, 8'd104, 8'd24, 8'd34, 8'd74, 8'd84, 8'd95};
    vec_t vecs [$];

    memory_fifo_tester_if #(.DATA_W(8)) bus ();

    memory_fifo_tester #(.DATA_W(8), .MEM_DEPTH(16), .FIFO_DEPTH(8)) dut (
        .clk  (clk),
        .rst1 (rst1),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] a, input logic s, input logic r);
        bus.W_en   = w;
        bus.port_A = a;
        bus.s_sig  = s;
        bus.R_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.W_en   = 1'b0;
        bus.port_A = 8'd0;
        bus.s_sig  = 1'b0;
        bus.R_en   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        rst1 = 1'b1;
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) cyc(1'b1, feat[i], 1'b0, 1'b0);
        idle_inputs();
    endtask

    task automatic check_weights(input string nm);
        for (int i = 0; i < 16; i++) chk($sformatf("%s weight[%0d]", nm, i), dut.weight_mem_q[i], feat[i]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // full-then-drain table: 8 pushes fill the FIFO, one stalled cycle, then 16 pops
        for (int k = 1; k <= 9; k++)
            vecs.push_back('{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, (k >= 8), 1'b0});
        for (int c = 1; c <= 16; c++)
            vecs.push_back('{1'b0, 8'd0, 1'b1, 1'b1, feat[c-1], (c == 16), 1'b0, (c >= 9)});
        vecs.push_back('{1'b0, 8'd0, 1'b1, 1'b1, 8'd95, 1'b1, 1'b0, 1'b1});

        idle_inputs();
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        chk("reset port_D", bus.port_D, 0);
        chk("reset fifo_empty", bus.fifo_empty, 1);
        chk("reset fifo_full", bus.fifo_full, 0);
        chk("reset xfer_done", bus.xfer_done, 0);
        rst1 = 1'b1;

        // load
        load_all();
        for (int i = 0; i < 16; i++) chk($sformatf("load feature[%0d]", i), dut.feature_mem_q[i], feat[i]);
        chk("load fifo_empty", bus.fifo_empty, 1);
        chk("load wr_addr wrap", dut.wr_addr_q, 0);

        // streaming transfer, occupancy stays at 1
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 8'd0, 1'b1, 1'b1);
            chk($sformatf("stream port_D edge %0d", k), bus.port_D,
                (k < 2) ? 0 : feat[(k - 2 > 15) ? 15 : k - 2]);
            chk($sformatf("stream fifo_empty edge %0d", k), bus.fifo_empty, (k >= 17) ? 1 : 0);
            chk($sformatf("stream fifo_full edge %0d", k), bus.fifo_full, 0);
        end
        idle_inputs();
        check_weights("stream");
        chk("stream xfer_done", bus.xfer_done, 1);
        chk("stream read_sync_cntr", dut.read_sync_cntr_q, 16);
        chk("stream j", dut.j_q, 0);

        // read while empty
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            chk($sformatf("empty-read port_D %0d", k), bus.port_D, 0);
            chk($sformatf("empty-read fifo_empty %0d", k), bus.fifo_empty, 1);
        end
        idle_inputs();
        chk("empty-read read_sync_cntr", dut.read_sync_cntr_q, 0);
        chk("empty-read rptr", dut.rptr_q, 0);
        chk("empty-read wptr", dut.wptr_q, 0);

        // fill to full, then drain
        do_reset();
        load_all();
        for (int v = 0; v < vecs.size(); v++) begin
            cyc(vecs[v].w_en, vecs[v].a, vecs[v].s, vecs[v].r);
            chk($sformatf("table[%0d] port_D", v), bus.port_D, vecs[v].exp_d);
            chk($sformatf("table[%0d] fifo_empty", v), bus.fifo_empty, vecs[v].exp_e);
            chk($sformatf("table[%0d] fifo_full", v), bus.fifo_full, vecs[v].exp_f);
            chk($sformatf("table[%0d] xfer_done", v), bus.xfer_done, vecs[v].exp_x);
            if (v == 7) chk("table src_cnt at full", dut.src_cnt_q, 8);
        end
        idle_inputs();
        check_weights("table");

        // asynchronous reset mid-transfer, then rerun
        do_reset();
        load_all();
        for (int k = 0; k < 6; k++) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        idle_inputs();
        chk("midreset pre read_sync_cntr", dut.read_sync_cntr_q, 5);
        rst1 = 1'b0;
        #2;
        chk("midreset fifo_empty", bus.fifo_empty, 1);
        chk("midreset port_D", bus.port_D, 0);
        chk("midreset xfer_done", bus.xfer_done, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("midreset feature[%0d]", i), dut.feature_mem_q[i], 0);
            chk($sformatf("midreset weight[%0d]", i), dut.weight_mem_q[i], 0);
        end
        @(posedge clk);
        #1;
        rst1 = 1'b1;
        load_all();
        for (int k = 0; k < 20; k++) cyc(1'b0, 8'd0, 1'b1, 1'b1);
        idle_inputs();
        check_weights("rerun");
        chk("rerun port_D", bus.port_D, 95);
        chk("rerun xfer_done", bus.xfer_done, 1);

        // 17th write wraps onto entry 0
        do_reset();
        load_all();
        cyc(1'b1, 8'd65, 1'b0, 1'b0);
        idle_inputs();
        chk("wrap feature[0]", dut.feature_mem_q[0], 65);
        for (int i = 1; i < 16; i++) chk($sformatf("wrap feature[%0d]", i), dut.feature_mem_q[i], feat[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_fifo_tester.md
# memory_fifo_tester

Self-checking memory-to-memory transfer block that stages 16 bytes in a feature memory and moves them through an internal FIFO into a weight memory. The path is feature memory, then FIFO, then weight memory. A host loads the feature memory byte-by-byte, pulses a start signal to stream the contents into the FIFO, and enables reading to drain the FIFO into the weight memory while presenting each drained byte on an output port. It sits in the FIFO verification harness as the device whose internal memories are compared after a run.

## Interface
- DATA_W, 8, data width of memories, FIFO and ports
- MEM_DEPTH, 16, entries in each of feature memory and weight memory (power of 2)
- FIFO_DEPTH, 8, FIFO entries (power of 2)
- clk  in  1  single clock; all state updates on rising edge
- rst1  in  1  asynchronous active-low reset
- W_en  in  1  feature-memory write enable
- port_A  in  DATA_W  feature-memory write data
- s_sig  in  1  transfer enable: feature memory into FIFO
- R_en  in  1  FIFO read enable: FIFO into weight memory and port_D
- port_D  out  DATA_W  last byte popped from FIFO (registered)
- fifo_empty  out  1  FIFO holds 0 words
- fifo_full  out  1  FIFO holds FIFO_DEPTH words
- xfer_done  out  1  all MEM_DEPTH words pushed into the FIFO

## Operation
- Internal arrays: Feature_Memory[MEM_DEPTH], Weight_Memory[MEM_DEPTH], FIFO storage[FIFO_DEPTH].
- Counters:
  - wr_addr: 4-bit, feature write address.
  - src_cnt: 5-bit, pushes issued.
  - FIFO wptr/rptr: log2(FIFO_DEPTH)+1 bits, with extra wrap bit.
  - j: 4-bit, weight write index.
  - read_sync_cntr: 5-bit, words popped.
- Load:
  - When W_en=1, Feature_Memory[wr_addr] <= port_A and wr_addr increments.
  - wr_addr wraps 15 to 0, so extra writes overwrite from entry 0.
- Push:
  - Condition: s_sig=1, fifo_full=0 and src_cnt<MEM_DEPTH.
  - FIFO[wptr] <= Feature_Memory[src_cnt[3:0]], then wptr and src_cnt increment.
  - The push uses the pre-edge memory value, so a W_en write in the same cycle is not seen.
- xfer_done = (src_cnt==MEM_DEPTH). Once set, further pushes stop until reset.
- Dropping s_sig pauses the transfer. Raising it again resumes at src_cnt.
- Pop:
  - Condition: R_en=1 and fifo_empty=0.
  - port_D and Weight_Memory[j] both take FIFO[rptr].
  - rptr, j and read_sync_cntr increment.
  - j wraps at 16; read_sync_cntr saturates at 31.
- A pop with R_en=1 while empty does nothing, and port_D holds its value.
- Push and pop in the same cycle are both performed; the occupancy count is unchanged.
- fifo_empty = (wptr==rptr).
- fifo_full = (low pointer bits equal) and (wrap bits differ).
- Both flags are combinational from the registered pointers.

## Timing
- Reset values (rst1=0, asynchronous):
  - All pointers and counters = 0.
  - port_D = 0, fifo_empty = 1, fifo_full = 0, xfer_done = 0.
  - Both memories cleared to 0.
- Reset mid-transfer aborts it and discards FIFO contents.
- Load: a byte presented on port_A with W_en=1 at edge N is stored at edge N.
- Push to pop:
  - A word pushed at edge N drops fifo_empty after edge N.
  - With R_en already high, it is popped at edge N+1.
  - port_D and Weight_Memory are valid after edge N+1.
- With s_sig=R_en=1 and the FIFO initially empty:
  - The first push happens at edge 1 and pops follow one cycle behind.
  - The 16th word appears on port_D after edge 17.
  - Occupancy never exceeds 1.
- One push and one pop per cycle maximum. There are no stalls other than full and empty.

## Test plan
- Reset, then load: write 4,14,24,42,141,243,41,134,204,124,104,24,34,74,84,95 on consecutive cycles -> Feature_Memory[0..15] holds exactly these values; fifo_empty=1.
- Load as above, then s_sig=R_en=1 for 20 cycles -> Weight_Memory[0..15] equals the feature list; port_D=95; xfer_done=1; fifo_empty=1; read_sync_cntr=16; j=0.
- Load, then s_sig=1 with R_en=0 -> fifo_full=1 after 8 cycles with src_cnt=8. Then raise R_en -> all 16 words arrive in order, ending with port_D=95.
- R_en=1 while empty for 5 cycles after reset -> port_D=0, read_sync_cntr=0, no pointer movement.
- Assert rst1=0 after 5 words have been transferred -> asynchronous clear: fifo_empty=1, port_D=0, memories 0. Re-run the load and transfer -> full correct result.
- Write 17 values (the 16 above, then 65) -> Feature_Memory[0]=65, other entries unchanged.
